// File: rtl/clken_gen.sv
// Multi-channel fractional clock-enable generator: one phase accumulator per
// channel, each with its own lock settle counter, sharing one valid/ready reconfig port.
module clken_gen #(
  parameter int                        CHANNELS    = 2,
  parameter int                        ACC_W       = 32,
  parameter logic [CHANNELS*ACC_W-1:0] INC_RESET   = {CHANNELS{32'd386547057}},
  parameter int                        LOCK_CYCLES = 16
) (
  input  logic                                            refclk,
  input  logic                                            rst_n,
  input  logic                                            cfg_valid,
  output logic                                            cfg_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
  input  logic [ACC_W-1:0]                                cfg_inc,
  output logic [CHANNELS-1:0]                             ce_out,
  output logic [CHANNELS-1:0]                             locked
);

  localparam logic [0:0]  ST_LOCKING = 1'b0;
  localparam logic [0:0]  ST_LOCKED  = 1'b1;
  localparam logic [15:0] LOCK_LAST  = 16'(LOCK_CYCLES - 1);

  logic [ACC_W-1:0]    acc_q   [CHANNELS];
  logic [ACC_W-1:0]    acc_d   [CHANNELS];
  logic [ACC_W-1:0]    inc_q   [CHANNELS];
  logic [ACC_W-1:0]    inc_d   [CHANNELS];
  logic [15:0]         cnt_q   [CHANNELS];
  logic [15:0]         cnt_d   [CHANNELS];
  logic [0:0]          state_q [CHANNELS];
  logic [0:0]          state_d [CHANNELS];
  logic [ACC_W:0]      sum     [CHANNELS];
  logic [CHANNELS-1:0] ce_q, ce_d;
  logic                ready_q, ready_d;
  logic                accept;
  logic                hit_any;

  always_comb begin
    locked = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      locked[i] = (state_q[i] == ST_LOCKED);
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    accept  = cfg_valid && ready_q;
    hit_any = 1'b0;
    ce_d    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i]     = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      acc_d[i]   = sum[i][ACC_W-1:0];
      inc_d[i]   = inc_q[i];
      cnt_d[i]   = cnt_q[i];
      state_d[i] = state_q[i];
      // Strobe uses the pre-edge lock state, so carries during settling are masked.
      ce_d[i]    = sum[i][ACC_W] && locked[i];

      if (state_q[i] == ST_LOCKING) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
        if (cnt_q[i] == LOCK_LAST) begin
          state_d[i] = ST_LOCKED;
        end
      end

      // Out-of-range channel numbers match no channel: accepted, then dropped.
      if (accept && (int'(cfg_chan) == i)) begin
        inc_d[i]   = cfg_inc;
        acc_d[i]   = '0;
        cnt_d[i]   = '0;
        state_d[i] = ST_LOCKING;
        ce_d[i]    = 1'b0;
        hit_any    = 1'b1;
      end
    end
    // Ready falls on the accept edge itself so a held cfg_valid cannot land twice.
    ready_d = (&locked) && !hit_any;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      // NOTE: these per-channel arrays are small register banks rather than a
      // RAM, so each entry takes the reset value directly.
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i]   <= '0;
        inc_q[i]   <= INC_RESET[i*ACC_W +: ACC_W];
        cnt_q[i]   <= '0;
        state_q[i] <= ST_LOCKING;
      end
      ce_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i]   <= acc_d[i];
        inc_q[i]   <= inc_d[i];
        cnt_q[i]   <= cnt_d[i];
        state_q[i] <= state_d[i];
      end
      ce_q    <= ce_d;
      ready_q <= ready_d;
    end
  end

  assign ce_out    = ce_q;
  assign cfg_ready = ready_q;

endmodule
